// File: rtl/sync_fifo_prog_pkg.sv
// rtl/sync_fifo_prog_pkg.sv - shared defaults and types for the programmable-threshold sync FIFO
package sync_fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 512;
    localparam int DEF_ADDR_SIZE  = 9;

    // Occupancy at the default geometry; one extra bit so FIFO_DEPTH itself fits.
    typedef logic [DEF_ADDR_SIZE:0] fifo_count_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - producer/consumer bus of the sync FIFO
interface sync_fifo_prog_if
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE
);
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [ADDR_SIZE:0]    afull_thresh;
    logic [ADDR_SIZE:0]    aempty_thresh;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_SIZE:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en, afull_thresh, aempty_thresh,
        input  data_out, rd_valid, wr_ack, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, afull_thresh, aempty_thresh,
        output data_out, rd_valid, wr_ack, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog_mem_dp.sv
// rtl/sync_fifo_prog_mem_dp.sv - dual-port storage array; SYNC_FIFO_FWFT_EN selects combinational read
module fifo_mem_dp
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_FIFO_WIDTH,
    parameter int DEPTH     = DEF_FIFO_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the read-side register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];

    logic unused_ok;
    assign unused_ok = rd_en ^ rst_n;
`else
    // Read-before-write: a same-address write in this cycle is not seen until later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds; SYNC_FIFO_FWFT_EN enables first-word-fall-through
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_prog_if.slave bus
);
    typedef logic [ADDR_SIZE:0] count_t;

    localparam count_t DEPTH_C = count_t'(FIFO_DEPTH);

    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    count_t                count_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [FIFO_WIDTH-1:0] mem_rd_data;
    fifo_status_t          st;

    // Flags are pure compares on the registered count; thresholds are used live.
    always_comb begin
        st.full         = (count_q == DEPTH_C);
        st.empty        = (count_q == '0);
        st.almost_full  = (count_q >= bus.afull_thresh);
        st.almost_empty = (count_q <= bus.aempty_thresh);
    end

    // A full FIFO still takes a write when a read frees a slot in the same cycle;
    // an empty FIFO never serves a read, even alongside a write.
    always_comb begin
        rd_acc = bus.rd_en && !st.empty;
        wr_acc = bus.wr_en && (!st.full || rd_acc);
    end

    // Pointers, occupancy and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            wr_ack_q    <= wr_acc;
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && !rd_acc;
        end
    end

    fifo_mem_dp #(
        .WIDTH     (FIFO_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is on display whenever there is one; zero otherwise.
    assign bus.rd_valid = !st.empty;
    assign bus.data_out = st.empty ? '0 : mem_rd_data;
`else
    logic rd_valid_q;

    // rd_valid accompanies the registered word one cycle after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.data_out = mem_rd_data;
`endif

    assign bus.full         = st.full;
    assign bus.empty        = st.empty;
    assign bus.almost_full  = st.almost_full;
    assign bus.almost_empty = st.almost_empty;
    assign bus.count        = count_q;
    assign bus.wr_ack       = wr_ack_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized self-checking bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;
    localparam int W = 16;
    localparam int D = 8;
    localparam int A = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_prog_if #(.FIFO_WIDTH(W), .ADDR_SIZE(A)) bus ();

    sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .ADDR_SIZE(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queue contents plus the expected registered outputs.
    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout = '0;
    logic exp_rd_valid = 1'b0;
    logic exp_wr_ack = 1'b0;
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit ra;
        bit wa;
        int n;
        if (!rst_n) begin
            q.delete();
            exp_dout = '0;
            exp_rd_valid = 1'b0;
            exp_wr_ack = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            n = q.size();
            ra = bus.rd_en && (n > 0);
            wa = bus.wr_en && ((n < D) || ra);
            exp_wr_ack = wa;
            exp_ovf = bus.wr_en && !wa;
            exp_udf = bus.rd_en && !ra;
            exp_rd_valid = ra;
            if (ra) exp_dout = q.pop_front();
            if (wa) q.push_back(bus.data_in);
        end
    end

    always @(negedge clk) begin
        int n;
        if (rst_n) begin
            n = q.size();
            check("count", 32'(bus.count), 32'(n));
            check("full", 32'(bus.full), 32'(n == D));
            check("empty", 32'(bus.empty), 32'(n == 0));
            check("almost_full", 32'(bus.almost_full), 32'(n >= int'(bus.afull_thresh)));
            check("almost_empty", 32'(bus.almost_empty), 32'(n <= int'(bus.aempty_thresh)));
            check("wr_ack", 32'(bus.wr_ack), 32'(exp_wr_ack));
            check("overflow", 32'(bus.overflow), 32'(exp_ovf));
            check("underflow", 32'(bus.underflow), 32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
            check("rd_valid", 32'(bus.rd_valid), 32'(n > 0));
            check("data_out", 32'(bus.data_out), (n > 0) ? 32'(q[0]) : 32'h0);
`else
            check("rd_valid", 32'(bus.rd_valid), 32'(exp_rd_valid));
            check("data_out", 32'(bus.data_out), 32'(exp_dout));
`endif
        end
    end

    task automatic step_d(input bit w, input bit r, input logic [W-1:0] d);
        bus.wr_en = w;
        bus.rd_en = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic step(input bit w, input bit r);
        step_d(w, r, W'($urandom));
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = '0;
        bus.afull_thresh = 4'd6;
        bus.aempty_thresh = 4'd2;

        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_pulses", 32'({bus.wr_ack, bus.overflow, bus.underflow}), 32'd0);
        check("rst_almost", 32'({bus.almost_full, bus.almost_empty}), 32'b01);

        for (int i = 1; i <= 10; i++) begin
            step(1, 0);
            check("fill_wr_ack", 32'(bus.wr_ack), 32'(i <= 8));
            check("fill_overflow", 32'(bus.overflow), 32'(i > 8));
        end
        check("fill_count", 32'(bus.count), 32'd8);
        check("fill_full", 32'(bus.full), 32'd1);

        for (int i = 1; i <= 10; i++) begin
            step(0, 1);
            check("drain_underflow", 32'(bus.underflow), 32'(i > 8));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_count", 32'(bus.count), 32'd0);

        repeat (8) step(1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1);
            check("simul_count", 32'(bus.count), 32'd8);
            check("simul_overflow", 32'(bus.overflow), 32'd0);
        end
        repeat (8) step(0, 1);
        check("simul_drain_empty", 32'(bus.empty), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
        step_d(1, 0, 16'hA5A5);
        check("fwft_data_out", 32'(bus.data_out), 32'h0000A5A5);
        check("fwft_rd_valid", 32'(bus.rd_valid), 32'd1);
        step(0, 1);
        check("fwft_pop_empty", 32'(bus.empty), 32'd1);
`else
        step_d(1, 0, 16'hA5A5);
        step(0, 1);
        check("std_data_out", 32'(bus.data_out), 32'h0000A5A5);
        check("std_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("std_pop_empty", 32'(bus.empty), 32'd1);
`endif

        for (int i = 1; i <= 7; i++) begin
            step(1, 0);
            if (i == 2) check("thr_ae_held", 32'(bus.almost_empty), 32'd1);
            if (i == 3) check("thr_ae_drop", 32'(bus.almost_empty), 32'd0);
            if (i == 5) check("thr_af_low", 32'(bus.almost_full), 32'd0);
            if (i == 6) check("thr_af_rise", 32'(bus.almost_full), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd1);
        check("midrst_full", 32'(bus.full), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            int wp;
            if ($urandom_range(0, 49) == 0) begin
                bus.afull_thresh = 4'($urandom_range(0, D + 2));
                bus.aempty_thresh = 4'($urandom_range(0, D + 2));
            end
            wp = ((i / 200) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO; the next generation of the team's FIFO block.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, write/read acknowledge, registered overflow/underflow pulses, and same-cycle read/write at full.
- Sits between same-clock producer/consumer stages wherever a clock-domain crossing is not required.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 512, number of entries; must be a power of two, minimum 4.
- ADDR_SIZE, 9, pointer width; must equal $clog2(FIFO_DEPTH).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- data_in  input  FIFO_WIDTH  write data.
- rd_en  input  1  read request.
- afull_thresh  input  ADDR_SIZE+1  almost_full threshold.
- aempty_thresh  input  ADDR_SIZE+1  almost_empty threshold.
- data_out  output  FIFO_WIDTH  read data.
- rd_valid  output  1  data_out holds a valid popped word.
- wr_ack  output  1  previous-cycle write accepted.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= afull_thresh.
- almost_empty  output  1  count <= aempty_thresh.
- count  output  ADDR_SIZE+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  previous-cycle write rejected.
- underflow  output  1  previous-cycle read rejected.

Behaviour:
- Reset: rst_n low asynchronously clears wr_ptr, rd_ptr, count, data_out, rd_valid, wr_ack, overflow and underflow; empty=1, full=0, almost_empty=1, almost_full=0 (thresholds nonzero). Storage array is not reset.
- Pointers are ADDR_SIZE bits and wrap naturally from FIFO_DEPTH-1 to 0. count is a separate register.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). Writing at full is allowed only when a read is accepted in the same cycle.
- A read at empty is always rejected, even with a simultaneous write; there is no bypass.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are combinational compares on registered count; they update in the cycle after the accepted operation.
- Threshold inputs are compared live. A threshold of 0 or above FIFO_DEPTH is legal and simply saturates the flag.
- wr_ack, overflow, underflow: registered one-cycle pulses, valid the cycle after the request.
  - wr_ack = wr_acc.
  - overflow = wr_en && !wr_acc.
  - underflow = rd_en && !rd_acc.
- Standard mode: data_out is registered with 1-cycle latency after rd_acc; rd_valid pulses with it. data_out holds its value when no read is accepted.
- Reset asserted mid-operation discards all contents immediately; the first write after release lands at address 0.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out shows the head word combinationally from the memory read port whenever !empty.
  - rd_valid = !empty.
  - rd_en acts as a pop/acknowledge of the displayed word; there is no read latency.
- Undefined: standard 1-cycle registered read as above.
- Flag, count and pulse behaviour are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - default-parameter localparams;
  - a typedef for the count type (logic [ADDR_SIZE:0]);
  - a status struct {full, empty, almost_full, almost_empty} for consumers.
- One sub-module, fifo_mem_dp: simple dual-port register array with synchronous write and read address input. It returns a registered read in standard mode and a combinational read under the macro.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> empty=1, count=0, data_out=0, all pulses 0.
- Fill/overflow (FIFO_DEPTH=8): write 10 random words -> count reaches 8, full=1 after the 8th write, wr_ack on writes 1-8, overflow pulses on writes 9-10, count stays 8.
- Drain/underflow: read 10 times from full -> data matches queue order with 1-cycle latency, empty=1 after the 8th read, underflow pulses on reads 9-10.
- Simultaneous at full: count=8, wr_en=rd_en=1 for 4 cycles -> count stays 8, no overflow, the 4 oldest words popped, the new words retained in order.
- Thresholds: afull_thresh=6, aempty_thresh=2; write 7 words one per cycle -> almost_empty drops after the 3rd write, almost_full rises after the 6th; reset mid-stream -> count=0 immediately.
- FWFT build: write 0xA5A5 into the empty FIFO -> next cycle data_out=0xA5A5 and rd_valid=1 with no rd_en; one rd_en -> empty=1.
